lcd_freq_display: RTL and testbench

Sequencer that drives an HD44780-compatible character LCD in 8-bit write-only mode and shows the most recent 16-bit frequency from the SPI receiver. It sits directly downstream of the SPI frequency receiver. Its inputs are that block's `frequency` word and its `new_SPI` strobe. After reset it runs the LCD power-up initialisation. Each time a new value is signalled, it converts the value to decimal and rewrites line 1 as a right-justified 5-digit number followed by " Hz".

---
 rtl/lcd_freq_display.sv | 184 ++++++++++++++++++
 tb/tb_lcd_freq_display.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_freq_display.sv
// HD44780 8-bit write-only sequencer: runs the power-up init, then rewrites line 1
// with the latest frequency as a right-justified 5-digit decimal followed by " Hz".
module lcd_freq_display #(
    parameter int POWERUP_CYC = 720000,
    parameter int EN_CYC      = 24,
    parameter int CMD_CYC     = 2400,
    parameter int CLR_CYC     = 96000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] frequency,
    input  logic        new_value,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data,
    output logic        busy,
    output logic        ready
);
    typedef enum logic [2:0] {S_PWR_WAIT, S_INIT, S_IDLE, S_CONVERT, S_WRITE} state_t;
    typedef enum logic [1:0] {P_SETUP, P_ENABLE, P_SETTLE} phase_t;

    localparam logic [31:0] PWR_LAST = 32'(POWERUP_CYC - 1);
    localparam logic [31:0] EN_LAST  = 32'(EN_CYC - 1);
    localparam logic [31:0] CMD_LAST = 32'(CMD_CYC - 1);
    localparam logic [31:0] CLR_LAST = 32'(CLR_CYC - 1);

    state_t      state_q, state_d;
    phase_t      phase_q;
    logic [31:0] cnt_q;
    logic [3:0]  byte_idx_q;
    logic [15:0] shadow_q, bin_q;
    logic        pending_q, ready_q;
    logic [19:0] bcd_q, bcd_adj;
    logic [7:0]  cur_byte;
    logic        cur_rs;
    logic [31:0] settle_last;
    logic        byte_done, last_byte, seq_done, enter_conv;
    logic [3:0]  d4, d3, d2, d1, d0;
    logic        blank4, blank3, blank2, blank1;

    assign d4 = bcd_q[19:16];
    assign d3 = bcd_q[15:12];
    assign d2 = bcd_q[11:8];
    assign d1 = bcd_q[7:4];
    assign d0 = bcd_q[3:0];
    // A digit is blanked only while every more-significant digit is also zero.
    assign blank4 = (d4 == 4'd0);
    assign blank3 = blank4 && (d3 == 4'd0);
    assign blank2 = blank3 && (d2 == 4'd0);
    assign blank1 = blank2 && (d1 == 4'd0);

    always_comb begin
        cur_byte = 8'h00;
        cur_rs   = 1'b0;
        if (state_q == S_INIT) begin
            case (byte_idx_q)
                4'd0, 4'd1: cur_byte = 8'h38;
                4'd2:       cur_byte = 8'h0C;
                4'd3:       cur_byte = 8'h01;
                default:    cur_byte = 8'h06;
            endcase
        end else if (state_q == S_WRITE) begin
            cur_rs = (byte_idx_q != 4'd0);
            case (byte_idx_q)
                4'd0:    cur_byte = 8'h80;
                4'd1:    cur_byte = blank4 ? 8'h20 : {4'h3, d4};
                4'd2:    cur_byte = blank3 ? 8'h20 : {4'h3, d3};
                4'd3:    cur_byte = blank2 ? 8'h20 : {4'h3, d2};
                4'd4:    cur_byte = blank1 ? 8'h20 : {4'h3, d1};
                4'd5:    cur_byte = {4'h3, d0};
                4'd6:    cur_byte = 8'h20;
                4'd7:    cur_byte = 8'h48;
                default: cur_byte = 8'h7A;
            endcase
        end
    end

    // Clear-display needs the long settle; it is the fourth init command.
    assign settle_last = (state_q == S_INIT && byte_idx_q == 4'd3) ? CLR_LAST : CMD_LAST;
    assign byte_done   = (phase_q == P_SETTLE) && (cnt_q == settle_last);
    assign last_byte   = (state_q == S_INIT) ? (byte_idx_q == 4'd4) : (byte_idx_q == 4'd8);
    assign seq_done    = byte_done && last_byte;
    assign enter_conv  = (state_d == S_CONVERT) && (state_q != S_CONVERT);

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_PWR_WAIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PWR_WAIT: if (cnt_q == PWR_LAST) state_d = S_INIT;
            S_INIT:     if (seq_done) state_d = S_IDLE;
            S_IDLE:     if (pending_q) state_d = S_CONVERT;
            S_CONVERT:  if (cnt_q == 32'd15) state_d = S_WRITE;
            S_WRITE:    if (seq_done) state_d = pending_q ? S_CONVERT : S_IDLE;
            default:    state_d = S_PWR_WAIT;
        endcase
    end

    always_comb begin
        lcd_e    = ((state_q == S_INIT) || (state_q == S_WRITE)) && (phase_q == P_ENABLE);
        lcd_rs   = cur_rs;
        lcd_data = cur_byte;
        lcd_rw   = 1'b0;
        busy     = (state_q != S_IDLE);
        ready    = ready_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= 32'd0;
            phase_q    <= P_SETUP;
            byte_idx_q <= 4'd0;
            shadow_q   <= 16'd0;
            pending_q  <= 1'b0;
            bin_q      <= 16'd0;
            bcd_q      <= 20'd0;
            ready_q    <= 1'b0;
        end else begin
            if (new_value) begin
                shadow_q  <= frequency;
                pending_q <= 1'b1;
            end else if (enter_conv) begin
                pending_q <= 1'b0;
            end

            if (enter_conv) begin
                bin_q <= shadow_q;
                bcd_q <= 20'd0;
            end else if (state_q == S_CONVERT) begin
                bcd_q <= {bcd_adj[18:0], bin_q[15]};
                bin_q <= {bin_q[14:0], 1'b0};
            end

            if (state_q == S_INIT && seq_done) ready_q <= 1'b1;

            if (state_d != state_q) begin
                cnt_q      <= 32'd0;
                phase_q    <= P_SETUP;
                byte_idx_q <= 4'd0;
            end else begin
                case (state_q)
                    S_PWR_WAIT, S_CONVERT: cnt_q <= cnt_q + 32'd1;
                    S_INIT, S_WRITE: begin
                        case (phase_q)
                            P_SETUP: begin
                                phase_q <= P_ENABLE;
                                cnt_q   <= 32'd0;
                            end
                            P_ENABLE: begin
                                if (cnt_q == EN_LAST) begin
                                    phase_q <= P_SETTLE;
                                    cnt_q   <= 32'd0;
                                end else begin
                                    cnt_q <= cnt_q + 32'd1;
                                end
                            end
                            default: begin
                                if (byte_done) begin
                                    phase_q    <= P_SETUP;
                                    cnt_q      <= 32'd0;
                                    byte_idx_q <= byte_idx_q + 4'd1;
                                end else begin
                                    cnt_q <= cnt_q + 32'd1;
                                end
                            end
                        endcase
                    end
                    default: cnt_q <= 32'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_freq_display.sv
// Bench for lcd_freq_display: expected LCD bytes are queued by the stimulus and
// checked by a monitor on every rising edge of lcd_e.
module tb_lcd_freq_display;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] frequency;
    logic        new_value;
    logic        lcd_rs, lcd_rw, lcd_e, busy, ready;
    logic [7:0]  lcd_data;

    lcd_freq_display #(.POWERUP_CYC(10), .EN_CYC(2), .CMD_CYC(4), .CLR_CYC(8)) dut (
        .clk(clk), .reset(reset), .frequency(frequency), .new_value(new_value),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
        .busy(busy), .ready(ready)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: {rs, data} per expected byte
    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int rise_count = 0;
    int last_rise_cyc = 0;
    logic e_prev = 1'b0;

    always @(negedge clk) begin
        logic [8:0] exp_b;
        if (lcd_e && !e_prev) begin
            rise_count++;
            last_rise_cyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL byte_unexpected: got rs=%0b data=%02h, required no byte", lcd_rs, lcd_data);
            end else begin
                exp_b = exp_q.pop_front();
                if ({lcd_rs, lcd_data} !== exp_b) begin
                    n_err++;
                    $display("FAIL byte: got rs=%0b data=%02h, required rs=%0b data=%02h",
                             lcd_rs, lcd_data, exp_b[8], exp_b[7:0]);
                end
            end
        end
        e_prev = lcd_e;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Driver tasks
    task automatic push_cmd(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
    endtask

    task automatic push_chr(input logic [7:0] b);
        exp_q.push_back({1'b1, b});
    endtask

    task automatic push_init();
        push_cmd(8'h38); push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h01); push_cmd(8'h06);
    endtask

    task automatic push_line(input logic [39:0] chars);
        push_cmd(8'h80);
        for (int i = 4; i >= 0; i--) push_chr(chars[8*i +: 8]);
        push_chr(8'h20); push_chr(8'h48); push_chr(8'h7A);
    endtask

    task automatic strobe(input logic [15:0] v, output int k);
        @(negedge clk);
        frequency = v;
        new_value = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        new_value = 1'b0;
    endtask

    task automatic wait_rise_to(input int target, input int budget, input string name);
        int n = 0;
        while (rise_count < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rise_count < target) check({"timeout_", name}, 32'(rise_count), 32'(target));
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        bit done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (exp_q.size() == 0 && !busy) done = 1;
        end
        if (!done) check({"timeout_", name}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, k, rc;
        int r[5];
        reset = 1'b0;
        new_value = 1'b0;
        frequency = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'd0, lcd_e, lcd_rs, lcd_rw, busy, ready, lcd_data},
              {19'd0, 5'b00010, 8'h00});

        // Init sequence and its timing
        push_init();
        rel = cyc;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rise_to(i + 1, 40, "init_rise");
            r[i] = last_rise_cyc;
        end
        check("init_first_e_delay", 32'(r[0] - rel), 32'd11);
        check("init_gap_0", 32'(r[1] - r[0]), 32'd7);
        check("init_gap_1", 32'(r[2] - r[1]), 32'd7);
        check("init_gap_2", 32'(r[3] - r[2]), 32'd7);
        check("init_gap_after_clear", 32'(r[4] - r[3]), 32'd11);
        repeat (5) @(negedge clk);
        check("ready_before_idle", {31'd0, ready}, 32'd0);
        check("busy_before_idle", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("ready_after_init", {31'd0, ready}, 32'd1);
        check("busy_after_init", {31'd0, busy}, 32'd0);
        check("init_drained", 32'(exp_q.size()), 32'd0);

        // Typical value 440
        push_line(40'h20_20_34_34_30);
        rc = rise_count;
        strobe(16'd440, k);
        wait_rise_to(rc + 1, 40, "first_rise_440");
        check("latency_to_e", 32'(last_rise_cyc - k), 32'd18);
        wait_drain(200, "drain_440");

        // Boundary values 0 and 65535
        push_line(40'h20_20_20_20_30);
        strobe(16'd0, k);
        wait_drain(200, "drain_0");
        check("rewrite_cycles", 32'(cyc - k), 32'd80);
        push_line(40'h36_35_35_33_35);
        strobe(16'd65535, k);
        wait_drain(200, "drain_65535");

        // Coalescing: 1000 then 2000 during the 500 rewrite
        rc = rise_count;
        push_line(40'h20_20_35_30_30);
        push_line(40'h20_32_30_30_30);
        strobe(16'd500, k);
        repeat (30) @(negedge clk);
        strobe(16'd1000, k);
        repeat (5) @(negedge clk);
        strobe(16'd2000, k);
        wait_drain(400, "drain_coalesce");
        repeat (60) @(negedge clk);
        check("coalesce_byte_count", 32'(rise_count - rc), 32'd18);
        check("coalesce_idle", {31'd0, busy}, 32'd0);

        // Early value during power-up wait
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_init();
        push_line(40'h20_31_32_33_34);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        strobe(16'd1234, k);
        wait_drain(600, "drain_early");
        check("ready_after_early", {31'd0, ready}, 32'd1);

        // Reset mid-write with a pending value
        push_line(40'h20_20_37_37_37);
        rc = rise_count;
        strobe(16'd777, k);
        wait_rise_to(rc + 1, 40, "rise_777");
        strobe(16'd999, k);
        wait_rise_to(rc + 3, 40, "rise_777_third");
        check("e_high_before_reset", {31'd0, lcd_e}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async_reset_outputs", {21'd0, lcd_e, lcd_rs, ready, lcd_data}, 32'd0);
        exp_q.delete();
        push_init();
        @(negedge clk);
        reset = 1'b1;
        wait_drain(400, "drain_reinit");
        check("ready_after_reinit", {31'd0, ready}, 32'd1);
        rc = rise_count;
        repeat (60) @(negedge clk);
        check("pending_discarded", 32'(rise_count - rc), 32'd0);
        check("idle_after_reinit", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
